// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit on a req/ready + rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned/invalid accesses.
module mem_stage_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            AddressingControlM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  FaultM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t state, state_nx;
  size_t  size, size_q;
  logic   access, is_load, f3_ok, uns, uns_q, bad;
  logic [1:0] off, off_q;
  logic [3:0] lane_be;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [DATA_WIDTH-1:0] lane_wdata, rd_ext;

  assign access  = MemWriteM | (ResultSrcM == 2'b01);
  assign is_load = ~MemWriteM;

  // funct3 decode; BU/HU only exist for loads, anything else invalid
  always_comb begin
    size  = SZ_W;
    uns   = 1'b0;
    f3_ok = 1'b1;
    case (AddressingControlM)
      3'b000: size = SZ_B;
      3'b001: size = SZ_H;
      3'b010: size = SZ_W;
      3'b100: begin
        size  = SZ_B;
        uns   = 1'b1;
        f3_ok = is_load;
      end
      3'b101: begin
        size  = SZ_H;
        uns   = 1'b1;
        f3_ok = is_load;
      end
      default: f3_ok = 1'b0;
    endcase
    if (!f3_ok) begin
      size = SZ_W;
      uns  = 1'b0;
    end
  end

  // Byte offset forced to natural alignment of the access size
  always_comb begin
    off = 2'b00;
    case (size)
      SZ_B:    off = ALUResultM[1:0];
      SZ_H:    off = {ALUResultM[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = ~f3_ok
             | ((size == SZ_H) & ALUResultM[0])
             | ((size == SZ_W) & (|ALUResultM[1:0]));
`else
  assign bad = 1'b0;
`endif

  // Store lane replication and byte enables
  always_comb begin
    lane_wdata = WriteDataM;
    lane_be    = 4'b1111;
    case (size)
      SZ_B: begin
        lane_wdata = {4{WriteDataM[7:0]}};
        lane_be    = 4'b0001 << off;
      end
      SZ_H: begin
        lane_wdata = {2{WriteDataM[15:0]}};
        lane_be    = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction from the latched offset/size
  always_comb begin
    rbyte = mem_rdata[{off_q, 3'b000} +: 8];
    rhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    rd_ext = {{24{~uns_q & rbyte[7]}}, rbyte};
      SZ_H:    rd_ext = {{16{~uns_q & rhalf[15]}}, rhalf};
      default: rd_ext = mem_rdata;
    endcase
  end

  assign mem_req = (state == REQ);
  assign StallM  = rst_n & (((state == IDLE) & access)
                          | (state == REQ)
                          | (state == WAIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (access) state_nx = bad ? DONE : REQ;
      REQ:  if (mem_ready) state_nx = mem_we ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the request on issue; capture load data on rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      ReadDataM <= '0;
    end else begin
      if ((state == IDLE) && access) begin
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata <= lane_wdata;
        mem_be    <= lane_be;
        size_q    <= size;
        uns_q     <= uns;
        off_q     <= off;
        if (bad && is_load) ReadDataM <= '0;
      end
      if ((state == WAIT) && mem_rvalid) ReadDataM <= rd_ext;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Fault flag is high exactly in the DONE cycle of a trapped access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) FaultM <= 1'b0;
    else        FaultM <= (state == IDLE) & access & bad;
  end
`else
  assign FaultM = 1'b0;
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the pipelined core.
- Consumes the execute→memory pipeline register outputs and drives a word-wide data-memory bus with a req/ready + rvalid handshake.
- Aligns store data with byte enables, and extracts and sign- or zero-extends load data.
- Asserts StallM while a transaction is outstanding, so the hazard logic freezes the F/D/E/M stages.

Parameters:
DATA_WIDTH, 32, data/address width (byte-lane logic is defined for 32 only)
ADDR_WIDTH, 32, bus address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ResultSrcM  in  2  2'b01 = load instruction in M stage
MemWriteM  in  1  store instruction in M stage
AddressingControlM  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  in  DATA_WIDTH  effective byte address
WriteDataM  in  DATA_WIDTH  store data (rs2)
StallM  out  1  hold pipeline (combinational)
ReadDataM  out  DATA_WIDTH  extended load result, registered
FaultM  out  1  access fault, registered (see optional feature)
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  word-aligned address (bits[1:0] = 0)
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM and FaultM all 0.
- Access definition: access = MemWriteM | (ResultSrcM==2'b01). If both are set, the access is a store.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On access: register address, funct3, lane data and be; set mem_req=1; go to REQ.
  - No access: stay.
  - mem_rvalid is ignored in this state.
- REQ:
  - mem_req held high; addr, wdata, be and we are stable until mem_ready=1.
  - On mem_ready: drop mem_req. Store → DONE; load → WAIT.
- WAIT:
  - On mem_rvalid: ReadDataM <= extract(mem_rdata); go to DONE.
  - mem_rvalid may arrive in the first WAIT cycle.
- DONE: one cycle, then IDLE. The pipeline advances at the end of this cycle.
- StallM = (IDLE & access) | REQ | WAIT. Low in DONE. This guarantees the same instruction is never re-issued.
- Latency with a zero-wait bus:
  - store: 2 stall cycles;
  - load: 3 stall cycles, with ReadDataM valid in the DONE cycle.
- ReadDataM holds its value until the next load completes.
- Store lanes:
  - SB: wdata = {4{d[7:0]}}, be = 1 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = d, be = 1111.
- Load extraction:
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: the full word.
- mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Inputs may change during a stall. All issued values come from the internal latches.
- Reset mid-transaction: mem_req drops immediately and the FSM returns to IDLE. A late rvalid is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access (H with addr[0]=1; W with addr[1:0]≠0) or an invalid funct3 issues no bus transaction.
  - IDLE → DONE directly, giving 1 stall cycle.
  - FaultM=1 during DONE only. ReadDataM <= 0 for loads.
- Undefined:
  - FaultM is tied to 0.
  - Low address bits are forced to natural alignment (H ignores addr[0]; W ignores addr[1:0]).
  - Invalid funct3 is treated as W.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, mem_ready=1 → one-cycle mem_req, mem_we=1, mem_addr 0x100, be 1111, StallM high for 2 cycles.
- LB addr 0x103, mem_rdata 0x80FFFFFF → ReadDataM 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH addr 0x102, data 0x1234ABCD → mem_wdata 0xABCDABCD, be 1100, mem_addr 0x100.
- SW with mem_ready held low 3 cycles → mem_req, addr and wdata stable throughout, StallM high for 5 cycles; WriteDataM changed mid-stall does not alter mem_wdata.
- Load stalled in WAIT, rst_n pulsed low → mem_req 0 and StallM 0 immediately; a subsequent mem_rvalid leaves ReadDataM at 0.
- LW addr 0x102: with LSU_MISALIGN_TRAP_EN → no mem_req, FaultM pulses 1, ReadDataM 0; without → mem_addr 0x100, be 1111.
